// File: rtl/pipelined_alu_unit.sv
// Two-stage pipelined signed ALU with saturating add/sub, an accumulator operand and
// valid/ready handshakes on both sides. Define ALU_MULT_EN to add the saturating multiply (opcode 10).
module pipelined_alu_unit #(
    parameter int WIDTH = 16,
    parameter int OPC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(8'h08);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(8'h09);
    localparam logic [OPC_W-1:0] OP_PASS = OPC_W'(8'h0a);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(8'h0b);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(8'h0c);
    localparam logic [OPC_W-1:0] OP_ASR  = OPC_W'(8'h0d);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(8'h0e);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(8'h0f);
`ifdef ALU_MULT_EN
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(8'h10);
`endif

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid_reg;
    logic [OPC_W-1:0] s1_opcode_reg;
    logic             s1_acc_sel_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] out_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] acc_reg;

    logic adv;
    logic s2_load;
    logic in_fire;

    // S2 can take a new result whenever it is empty or its current one is leaving.
    assign adv      = !s2_valid_reg || out_ready;
    assign s2_load  = adv && s1_valid_reg;
    assign in_ready = !s1_valid_reg || adv;
    assign in_fire  = in_valid && in_ready;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             shamt_big;
    logic [WIDTH-1:0] asr_val;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;
`ifdef ALU_MULT_EN
    logic signed [2*WIDTH-1:0] prod;
    logic                      prod_fits;
`endif

    // acc_reg is written on the same edge the previous op enters S2, so a dependent op in S1 sees it directly.
    assign op_a      = s1_acc_sel_reg ? acc_reg : s1_a_reg;
    assign a_ext     = {op_a[WIDTH-1], op_a};
    assign b_ext     = {s1_b_reg[WIDTH-1], s1_b_reg};
    assign sum_ext   = a_ext + b_ext;
    assign diff_ext  = a_ext - b_ext;
    assign shamt_big = (s1_b_reg >= WIDTH'(WIDTH));
    assign asr_val   = shamt_big ? {WIDTH{op_a[WIDTH-1]}} : WIDTH'($signed(op_a) >>> s1_b_reg);
    assign shl_val   = shamt_big ? '0 : (op_a << s1_b_reg);
`ifdef ALU_MULT_EN
    assign prod      = $signed(op_a) * $signed(s1_b_reg);
    // The product fits when every bit above the result's sign bit repeats that sign bit.
    assign prod_fits = (prod[2*WIDTH-1:WIDTH-1] == '0) || (prod[2*WIDTH-1:WIDTH-1] == '1);
`endif

    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
        case (s1_opcode_reg)
            OP_SUB: begin
                if (diff_ext[WIDTH] != diff_ext[WIDTH-1]) begin
                    res_next = diff_ext[WIDTH] ? MIN_NEG : MAX_POS;
                    ovf_next = 1'b1;
                end else begin
                    res_next = diff_ext[WIDTH-1:0];
                end
            end
            OP_PASS: res_next = s1_b_reg;
            OP_AND:  res_next = op_a & s1_b_reg;
            OP_OR:   res_next = op_a | s1_b_reg;
            OP_ASR:  res_next = asr_val;
            OP_SHL:  res_next = shl_val;
            OP_XOR:  res_next = op_a ^ s1_b_reg;
`ifdef ALU_MULT_EN
            OP_MUL: begin
                if (prod_fits) begin
                    res_next = prod[WIDTH-1:0];
                end else begin
                    res_next = prod[2*WIDTH-1] ? MIN_NEG : MAX_POS;
                    ovf_next = 1'b1;
                end
            end
`endif
            default: begin
                if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
                    res_next = sum_ext[WIDTH] ? MIN_NEG : MAX_POS;
                    ovf_next = 1'b1;
                end else begin
                    res_next = sum_ext[WIDTH-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_opcode_reg  <= OP_ADD;
            s1_acc_sel_reg <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_reg   <= 1'b1;
                s1_opcode_reg  <= opcode;
                s1_acc_sel_reg <= acc_sel;
                s1_a_reg       <= in_a;
                s1_b_reg       <= in_b;
            end else if (s2_load) begin
                s1_valid_reg   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            out_reg      <= '0;
            ovf_reg      <= 1'b0;
            acc_reg      <= '0;
        end else begin
            if (adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s2_load) begin
                out_reg <= res_next;
                ovf_reg <= ovf_next;
                acc_reg <= res_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out       = out_reg;
    assign ovf       = ovf_reg;
    assign zero      = (out_reg == '0);
    assign neg       = out_reg[WIDTH-1];

endmodule

// File: tb/tb_pipelined_alu_unit.sv
// Directed self-checking bench for pipelined_alu_unit (WIDTH=16); covers the multiply
// vectors when ALU_MULT_EN is defined and the default-add fallback of opcode 10 otherwise.
module tb_pipelined_alu_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   opcode = 8'h00;
    logic         acc_sel = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         ovf;
    logic         zero;
    logic         neg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   s_op  [3];
    logic         s_sel [3];
    logic [W-1:0] s_b   [3];
    logic [W-1:0] s_exp [3];

    pipelined_alu_unit #(.WIDTH(W), .OPC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .acc_sel   (acc_sel),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Issue one op into an empty pipeline with out_ready=1 and check latency and result.
    task automatic single_op(input string tag, input logic [7:0] op, input logic sel,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_out, input logic exp_ovf);
        @(negedge clk);
        opcode = op; acc_sel = sel; in_a = a; in_b = b; in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; acc_sel = 1'b0;
        @(negedge clk);
        check({tag, ".lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".lat2"}, 32'(out_valid), 32'd1);
        check({tag, ".out"},  32'(out), 32'(exp_out));
        check({tag, ".ovf"},  32'(ovf), 32'(exp_ovf));
        check({tag, ".zero"}, 32'(zero), 32'(exp_out == '0));
        check({tag, ".neg"},  32'(neg), 32'(exp_out[W-1]));
        $display("op %h sel %b a %h b %h -> out %h ovf %b", op, sel, a, b, out, ovf);
    endtask

    initial begin
        s_op[0] = 8'h0a; s_sel[0] = 1'b0; s_b[0] = 16'h0011; s_exp[0] = 16'h0011;
        s_op[1] = 8'h08; s_sel[1] = 1'b1; s_b[1] = 16'h0001; s_exp[1] = 16'h0012;
        s_op[2] = 8'h08; s_sel[2] = 1'b1; s_b[2] = 16'h0010; s_exp[2] = 16'h0022;

        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out",       32'(out), 32'd0);
        check("rst.ovf",       32'(ovf), 32'd0);
        check("rst.zero",      32'(zero), 32'd1);
        check("rst.neg",       32'(neg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready",  32'(in_ready), 32'd1);

        single_op("add_posovf", 8'h08, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
        single_op("sub_negovf", 8'h09, 1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b1);
        single_op("sub_zero",   8'h09, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b0);
        single_op("add_neg",    8'h08, 1'b0, 16'hFFFB, 16'hFFFD, 16'hFFF8, 1'b0);
        single_op("asr_big",    8'h0d, 1'b0, 16'h8000, 16'h0014, 16'hFFFF, 1'b0);
        single_op("asr_4",      8'h0d, 1'b0, 16'h8000, 16'h0004, 16'hF800, 1'b0);
        single_op("shl_15",     8'h0e, 1'b0, 16'h0001, 16'h000F, 16'h8000, 1'b0);
        single_op("shl_16",     8'h0e, 1'b0, 16'h0001, 16'h0010, 16'h0000, 1'b0);
        single_op("and",        8'h0b, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
        single_op("or",         8'h0c, 1'b0, 16'hF000, 16'h000F, 16'hF00F, 1'b0);
        single_op("xor",        8'h0f, 1'b0, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0);
        single_op("pass",       8'h0a, 1'b0, 16'hAAAA, 16'h1234, 16'h1234, 1'b0);
        single_op("dflt_add",   8'h55, 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0);
`ifdef ALU_MULT_EN
        single_op("mul_sat",    8'h10, 1'b0, 16'h0100, 16'h0100, 16'h7FFF, 1'b1);
        single_op("mul_neg",    8'h10, 1'b0, 16'hFFFE, 16'h0003, 16'hFFFA, 1'b0);
`else
        single_op("op10_add",   8'h10, 1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b1);
`endif

        // Back-to-back dependent ops through the accumulator.
        @(negedge clk);
        opcode = 8'h0a; acc_sel = 1'b0; in_a = 16'h5555; in_b = 16'h0003; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opcode = 8'h08; acc_sel = 1'b1; in_a = 16'h7000; in_b = 16'h0004;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; acc_sel = 1'b0;
        check("chain.valid1", 32'(out_valid), 32'd1);
        check("chain.out1",   32'(out), 32'h0003);
        @(negedge clk);
        check("chain.valid2", 32'(out_valid), 32'd1);
        check("chain.out2",   32'(out), 32'h0007);
        $display("chain -> 0003 then %h", out);
        repeat (2) @(negedge clk);

        // Backpressure: out_ready low for 5 cycles while 3 ops are offered.
        begin
            int issued = 0;
            int recv = 0;
            logic fire;
            for (int cyc = 0; cyc < 40 && recv < 3; cyc++) begin
                @(negedge clk);
                out_ready = (cyc >= 5);
                if (issued < 3) begin
                    in_valid = 1'b1; opcode = s_op[issued]; acc_sel = s_sel[issued];
                    in_a = 16'h7777; in_b = s_b[issued];
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (cyc == 2) check("stall.in_ready", 32'(in_ready), 32'd0);
                if (cyc >= 2 && cyc < 5) begin
                    check("stall.hold_valid", 32'(out_valid), 32'd1);
                    check("stall.hold_out",   32'(out), 32'h0011);
                end
                if (cyc == 4) check("stall.accepted", 32'(issued), 32'd2);
                if (out_valid && out_ready) begin
                    check("stall.order", 32'(out), 32'(s_exp[recv]));
                    $display("stall result %0d -> out %h", recv, out);
                    recv++;
                end
                fire = in_valid && in_ready;
                @(posedge clk);
                if (fire) issued++;
            end
            #1 in_valid = 1'b0; acc_sel = 1'b0;
            check("stall.delivered", 32'(recv), 32'd3);
        end
        repeat (2) @(negedge clk);

        // Reset while two ops are held in flight.
        @(negedge clk);
        out_ready = 1'b0;
        opcode = 8'h0a; acc_sel = 1'b0; in_b = 16'h0055; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_b = 16'h0066;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.out",       32'(out), 32'd0);
        check("midrst.zero",      32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst.no_pulse1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("midrst.no_pulse2", 32'(out_valid), 32'd0);
        $display("mid-op reset done");
        single_op("acc_cleared", 8'h08, 1'b1, 16'h1234, 16'h0002, 16'h0002, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
